// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared IFU definitions.
//   ifu_state_t   - fetch FSM states
//   RESET_PC_DEFAULT, INST_W, PC_W, IFU_DATA_W and field offsets of ifu_data
//   pack_ifu_data - builds {inst, pc} for the IFU->IDU channel
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_RSP,
        S_HOLD,
        S_WAIT
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned INST_W           = 32;
    localparam int unsigned PC_W             = 32;
    localparam int unsigned IFU_DATA_W       = 64;
    localparam int unsigned IFU_INST_LSB     = 32;  // inst occupies [63:32]
    localparam int unsigned IFU_PC_LSB       = 0;   // pc occupies [31:0]

    function automatic logic [IFU_DATA_W-1:0] pack_ifu_data(
        input logic [INST_W-1:0] inst,
        input logic [PC_W-1:0]   pc
    );
        logic [IFU_DATA_W-1:0] d;
        d = '0;
        d[IFU_INST_LSB +: INST_W] = inst;
        d[IFU_PC_LSB   +: PC_W]   = pc;
        return d;
    endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: IFU performance counters.
//   clk, rst       - clock, synchronous active-high reset (clears counters)
//   transfer       - one IFU->IDU transfer this cycle
//   stall          - ifu_valid held without idu_ready this cycle
//   fetch_cnt      - number of transfers, wraps modulo 2^PERF_W
//   stall_cnt      - number of stall cycles, wraps modulo 2^PERF_W
module ifu_perf_cnt #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              transfer,
    input  logic              stall,
    output logic [PERF_W-1:0] fetch_cnt,
    output logic [PERF_W-1:0] stall_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (transfer) fetch_cnt <= fetch_cnt + 1'b1;
            if (stall)    stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch unit, producer of IFU->IDU channel.
// Fetches one instruction per loop: request -> response -> hand to IDU ->
// wait for the back end to commit the next PC.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr - fetch request (addr = current pc)
//   imem_rsp_valid, imem_rsp_data   - fetch response (single-cycle pulse)
//   ifu_valid, ifu_data, idu_ready  - {inst, pc} toward IDU
//   pc_update_valid/target          - committed next PC (single-cycle pulse)
//   perf_fetch_cnt, perf_stall_cnt  - present only with IFU_PERF_EN defined
// Optional feature macro: IFU_PERF_EN (performance counters).
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [31:0]           imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic                  ifu_valid,
    output logic [IFU_DATA_W-1:0] ifu_data,
    input  logic                  idu_ready,
    input  logic                  pc_update_valid,
    input  logic [31:0]           pc_update_target
`ifdef IFU_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_fetch_cnt,
    output logic [PERF_W-1:0]     perf_stall_cnt
`endif
);

    ifu_state_t        state;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            inst    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) state <= S_RSP;
                end
                S_RSP: begin
                    if (imem_rsp_valid) begin
                        inst    <= imem_rsp_data;
                        valid_q <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // pc_update_valid in this (transfer) cycle is deliberately ignored
                    if (idu_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pc_update_valid) begin
                        pc    <= pc_update_target;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Decoded from state (not registered) so the request appears in the very
    // first cycle after reset; gated by rst so it stays low during reset.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_addr      = pc;
    assign ifu_valid      = valid_q;
    assign ifu_data       = pack_ifu_data(inst, pc);

`ifdef IFU_PERF_EN
    logic transfer;
    logic stall;

    assign transfer = valid_q &  idu_ready;
    assign stall    = valid_q & ~idu_ready;

    ifu_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .transfer  (transfer),
        .stall     (stall),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`else
    logic unused_perf_w;
    assign unused_perf_w = ^32'(PERF_W);
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch. Expected request addresses
// and IDU transfers are queued by the stimulus thread; a negedge monitor pops
// and compares whenever a request is accepted or a transfer occurs.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ifu_valid;
    logic [63:0] ifu_data;
    logic        idu_ready;
    logic        pc_update_valid;
    logic [31:0] pc_update_target;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];

    ifu_fetch #(
        .RESET_PC (32'h8000_0000),
        .PERF_W   (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .ifu_valid        (ifu_valid),
        .ifu_data         (ifu_data),
        .idu_ready        (idu_ready),
        .pc_update_valid  (pc_update_valid),
        .pc_update_target (pc_update_target)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares accepted requests and IDU transfers against queues
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            if (exp_addr.size() == 0) begin
                n_checks++;
                $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
            end else begin
                check("req_addr", {32'h0, imem_addr}, {32'h0, exp_addr.pop_front()});
            end
        end
        if (!rst && ifu_valid && idu_ready) begin
            if (exp_data.size() == 0) begin
                n_checks++;
                $display("FAIL xfer_unexpected: got data %h expected no transfer", ifu_data);
            end else begin
                check("xfer_data", ifu_data, exp_data.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        imem_req_ready   = 1'b1;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = '0;
        idu_ready        = 1'b0;
        pc_update_valid  = 1'b0;
        pc_update_target = '0;

        // Reset: no valid, no request
        repeat (3) begin
            @(negedge clk);
            check("rst_ifu_valid", {63'h0, ifu_valid}, 64'h0);
            check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        end

        tick();
        rst = 1'b0;
        exp_addr.push_back(32'h8000_0000);
        @(negedge clk);
        check("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("first_req_addr", {32'h0, imem_addr}, 64'h8000_0000);

        // S_RSP: response plus a stray pc update (must be ignored)
        tick();
        imem_rsp_valid   = 1'b1;
        imem_rsp_data    = 32'h0000_0413;
        idu_ready        = 1'b1;
        pc_update_valid  = 1'b1;
        pc_update_target = 32'hdead_beef;
        exp_data.push_back(64'h0000_0413_8000_0000);
        @(negedge clk);
        check("rsp_no_valid", {63'h0, ifu_valid}, 64'h0);
        check("rsp_no_req", {63'h0, imem_req_valid}, 64'h0);

        tick();
        imem_rsp_valid  = 1'b0;
        pc_update_valid = 1'b0;
        @(negedge clk);
        check("hold_valid", {63'h0, ifu_valid}, 64'h1);
        check("hold_data", ifu_data, 64'h0000_0413_8000_0000);

        tick();
        @(negedge clk);
        check("valid_one_cycle", {63'h0, ifu_valid}, 64'h0);
        check("wait_no_req", {63'h0, imem_req_valid}, 64'h0);

        // Stray response in S_WAIT
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hffff_ffff;
        @(negedge clk);
        check("stray_rsp_valid", {63'h0, ifu_valid}, 64'h0);
        tick();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        check("stray_rsp_valid2", {63'h0, ifu_valid}, 64'h0);
        check("stray_rsp_inst", ifu_data, 64'h0000_0413_8000_0000);

        // Commit next PC, then hold the request off for 3 cycles
        tick();
        pc_update_valid  = 1'b1;
        pc_update_target = 32'h8000_0100;
        imem_req_ready   = 1'b0;
        exp_addr.push_back(32'h8000_0100);
        tick();
        pc_update_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_req_valid", {63'h0, imem_req_valid}, 64'h1);
            check("held_req_addr", {32'h0, imem_addr}, 64'h8000_0100);
            tick();
        end
        imem_req_ready = 1'b1;
        @(negedge clk);

        // Response, then IDU stalls 5 cycles
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00a0_0093;
        idu_ready      = 1'b0;
        exp_data.push_back(64'h00a0_0093_8000_0100);
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {63'h0, ifu_valid}, 64'h1);
            check("stall_data", ifu_data, 64'h00a0_0093_8000_0100);
            tick();
        end
        idu_ready = 1'b1;
        @(negedge clk);
        check("ready_xfer_valid", {63'h0, ifu_valid}, 64'h1);
        tick();
        @(negedge clk);
        check("after_xfer_valid", {63'h0, ifu_valid}, 64'h0);
`ifdef IFU_PERF_EN
        check("perf_stall", {32'h0, perf_stall_cnt}, 64'd5);
        check("perf_fetch", {32'h0, perf_fetch_cnt}, 64'd2);
`endif

        // Third fetch, reset while holding
        tick();
        pc_update_valid  = 1'b1;
        pc_update_target = 32'h8000_0200;
        exp_addr.push_back(32'h8000_0200);
        tick();
        pc_update_valid = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        idu_ready      = 1'b0;
        tick();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        check("third_hold_data", ifu_data, 64'h1234_5678_8000_0200);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_valid", {63'h0, ifu_valid}, 64'h0);
        check("midrst_data", ifu_data, 64'h0000_0000_8000_0000);
        check("midrst_req", {63'h0, imem_req_valid}, 64'h0);
`ifdef IFU_PERF_EN
        check("midrst_perf_fetch", {32'h0, perf_fetch_cnt}, 64'd0);
        check("midrst_perf_stall", {32'h0, perf_stall_cnt}, 64'd0);
`endif
        tick();
        rst = 1'b0;
        exp_addr.push_back(32'h8000_0000);
        @(negedge clk);
        check("reissue_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("reissue_req_addr", {32'h0, imem_addr}, 64'h8000_0000);
        tick();
        tick();
        @(negedge clk);
        check("addr_queue_drained", 64'(exp_addr.size()), 64'd0);
        check("data_queue_drained", 64'(exp_data.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
